// File: rtl/am_audio_pkg.sv
// Shared types and width helpers for the AM audio decimator and its DC blocker.
package am_audio_pkg;

  typedef enum logic {PRIME, RUN} am_audio_state_t;

  // Block accumulator: a full block of max-scale samples fits without wrap.
  function automatic int acc_w(input int data_width, input int decim_log2);
    return data_width + 1 + decim_log2;
  endfunction

  function automatic int dc_acc_w(input int data_width, input int dc_shift);
    return data_width + 1 + dc_shift;
  endfunction

  // Difference of two (DATA_WIDTH+1)-bit unsigned values is exact in this width.
  function automatic int diff_w(input int data_width);
    return data_width + 2;
  endfunction

endpackage

// File: rtl/am_dc_blocker.sv
// Leaky-integrator DC removal on decimated envelope samples.
// The first block after reset seeds the DC estimate; later blocks emit audio.
module am_dc_blocker
  import am_audio_pkg::*;
#(
  parameter int DATA_WIDTH = 12,
  parameter int DC_SHIFT   = 6
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [DATA_WIDTH:0]                avg,
  input  logic                               dump,
  output logic signed [diff_w(DATA_WIDTH)-1:0] audio_out,
  output logic                               audio_valid
);

  localparam int DCW = dc_acc_w(DATA_WIDTH, DC_SHIFT);
  localparam int DFW = diff_w(DATA_WIDTH);

  am_audio_state_t         state_q, state_d;
  logic [DCW-1:0]          dc_acc_q, dc_acc_d;
  logic [DATA_WIDTH:0]     dc;
  logic signed [DFW-1:0]   diff, audio_d;
  logic signed [DCW-1:0]   diff_ext;
  logic                    valid_d;

  assign dc       = dc_acc_q[DCW-1:DC_SHIFT];
  assign diff     = $signed({1'b0, avg}) - $signed({1'b0, dc});
  assign diff_ext = DCW'(diff);

  always_comb begin
    state_d  = state_q;
    dc_acc_d = dc_acc_q;
    audio_d  = audio_out;
    valid_d  = 1'b0;
    if (dump) begin
      case (state_q)
        PRIME: begin
          dc_acc_d = {avg, {DC_SHIFT{1'b0}}};
          state_d  = RUN;
        end
        RUN: begin
          audio_d  = diff;
          valid_d  = 1'b1;
          // Estimate moves a fraction of the way toward avg, so it stays >= 0.
          dc_acc_d = dc_acc_q + $unsigned(diff_ext);
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= PRIME;
      dc_acc_q    <= '0;
      audio_out   <= '0;
      audio_valid <= 1'b0;
    end else begin
      state_q     <= state_d;
      dc_acc_q    <= dc_acc_d;
      audio_out   <= audio_d;
      audio_valid <= valid_d;
    end
  end

endmodule

// File: rtl/am_audio_decimator.sv
// Accumulate-and-dump decimator by 2^DECIM_LOG2 feeding a DC blocker,
// turning the detector's envelope magnitude into signed audio samples.
module am_audio_decimator
  import am_audio_pkg::*;
#(
  parameter int DATA_WIDTH = 12,
  parameter int DECIM_LOG2 = 8,
  parameter int DC_SHIFT   = 6
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [DATA_WIDTH:0]                amdemod_in,
  input  logic                               in_valid,
  output logic signed [diff_w(DATA_WIDTH)-1:0] audio_out,
  output logic                               audio_valid
);

  localparam int AW = acc_w(DATA_WIDTH, DECIM_LOG2);

  logic [AW-1:0]         acc, acc_sum;
  logic [DECIM_LOG2-1:0] cnt;
  logic [DATA_WIDTH:0]   avg;
  logic                  dump;

  // The dump-cycle sample is folded into its own block's average.
  assign acc_sum = acc + AW'(amdemod_in);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc  <= '0;
      cnt  <= '0;
      avg  <= '0;
      dump <= 1'b0;
    end else begin
      dump <= 1'b0;
      if (in_valid) begin
        if (&cnt) begin
          avg  <= acc_sum[AW-1:DECIM_LOG2];
          acc  <= '0;
          cnt  <= '0;
          dump <= 1'b1;
        end else begin
          acc  <= acc_sum;
          cnt  <= cnt + DECIM_LOG2'(1);
        end
      end
    end
  end

  am_dc_blocker #(
    .DATA_WIDTH (DATA_WIDTH),
    .DC_SHIFT   (DC_SHIFT)
  ) u_dc_blocker (
    .clk         (clk),
    .rst         (rst),
    .avg         (avg),
    .dump        (dump),
    .audio_out   (audio_out),
    .audio_valid (audio_valid)
  );

endmodule

// File: tb/tb_am_audio_decimator.sv
// Randomized bench for am_audio_decimator against a block-level arithmetic model.
module tb_am_audio_decimator;

  localparam int DW = 12;
  localparam int DL = 2;
  localparam int DS = 6;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [DW:0]          amdemod_in;
  logic                 in_valid;
  logic signed [DW+1:0] audio_out;
  logic                 audio_valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  am_audio_decimator #(.DATA_WIDTH(DW), .DECIM_LOG2(DL), .DC_SHIFT(DS)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .amdemod_in  (amdemod_in),
    .in_valid    (in_valid),
    .audio_out   (audio_out),
    .audio_valid (audio_valid)
  );

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s obs=%0d exp=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Model: expected strobes with the edge index at which they must appear.
  typedef struct {int e; longint v;} exp_t;
  exp_t   q[$];
  int     ecount   = 0;
  longint acc_m    = 0;
  int     cnt_m    = 0;
  bit     run_m    = 0;
  longint dcacc_m  = 0;
  longint last_exp = 0;

  always @(posedge clk or posedge rst) begin
    longint avg_m, d_m;
    if (rst) begin
      acc_m = 0; cnt_m = 0; run_m = 0; dcacc_m = 0; last_exp = 0;
      q.delete();
    end else begin
      ecount++;
      if (in_valid) begin
        acc_m += longint'(amdemod_in);
        cnt_m++;
        if (cnt_m == (1 << DL)) begin
          avg_m = acc_m / (64'sd1 << DL);
          acc_m = 0;
          cnt_m = 0;
          if (!run_m) begin
            dcacc_m = avg_m * (64'sd1 << DS);
            run_m   = 1;
          end else begin
            d_m = avg_m - dcacc_m / (64'sd1 << DS);
            q.push_back('{ecount + 1, d_m});
            dcacc_m += d_m;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    bit ev;
    if (!rst) begin
      ev = (q.size() > 0) && (q[0].e == ecount);
      chk("valid", longint'(audio_valid), longint'(ev));
      if (ev) begin
        last_exp = q[0].v;
        void'(q.pop_front());
      end
      chk("audio", longint'(audio_out), last_exp);
    end
  end

  task automatic drive(input bit v, input int d);
    @(negedge clk);
    in_valid   = v;
    amdemod_in = 13'(d);
  endtask

  task automatic mid_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("rst_audio", longint'(audio_out), 0);
    chk("rst_valid", longint'(audio_valid), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int blk[8];
    rst = 1'b1; in_valid = 1'b0; amdemod_in = '0;
    repeat (3) @(negedge clk);
    chk("reset_audio", longint'(audio_out), 0);
    chk("reset_valid", longint'(audio_valid), 0);
    rst = 1'b0;

    repeat (24) drive(1, 1000);
    repeat (40) drive(1, 1064);
    mid_reset();

    blk = '{0, 1, 2, 3, 5, 5, 5, 6};
    foreach (blk[i]) drive(1, blk[i]);
    repeat (3) drive(0, 0);

    repeat (300) drive($urandom_range(0, 3) != 0, $urandom_range(0, 8191));

    repeat (8) drive(1, 2000);
    repeat (6) drive(1, 2500);
    mid_reset();
    repeat (12) drive(1, 3000);

    repeat (16) drive(1, 8191);
    repeat (60) drive(1, 0);

    repeat (300) drive($urandom_range(0, 1), $urandom_range(0, 8191));
    drive(0, 0);
    repeat (4) @(negedge clk);
    chk("drain", longint'(q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
